// File: rtl/alarm_pkg.sv
// Shared types and width helpers for the multi-channel alarm unit.
package alarm_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t h_t;
    bcd_t h_o;
    bcd_t m_t;
    bcd_t m_o;
  } hhmm_t;

  function automatic int RING_CNT_W(input int secs);
    return (secs < 2) ? 1 : $clog2(secs + 1);
  endfunction

  function automatic int SNOOZE_CNT_W(input int secs);
    return (secs < 2) ? 1 : $clog2(secs + 1);
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm channel: stored HH:MM, arm flag, edge detect, ring timer.
// Snooze counter exists only when ALARM_SNOOZE_EN is defined.
module alarm_slot
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sec_tick,
  input  logic [15:0] now,
  input  logic [15:0] set_val,
  input  logic        wr,
  input  logic        clr,
  input  logic        stop,
  input  logic        snooze,
  output logic        ringing,
  output logic        armed
);

  localparam int RW = RING_CNT_W(RING_SECS);
  localparam logic [RW-1:0] RING_LD = RW'(RING_SECS);

  hhmm_t          alm;
  logic [RW-1:0]  ring_cnt;
  logic           match;
  logic           match_q;
  logic           trig;

  assign match = armed & (hhmm_t'(now) == alm);
  assign trig  = match & ~match_q;

`ifdef ALARM_SNOOZE_EN
  localparam int SW = SNOOZE_CNT_W(SNOOZE_SECS);
  localparam logic [SW-1:0] SNZ_LD = SW'(SNOOZE_SECS);

  logic [SW-1:0] snz_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      alm      <= '0;
      armed    <= 1'b0;
      match_q  <= 1'b0;
      ringing  <= 1'b0;
      ring_cnt <= '0;
      snz_cnt  <= '0;
    end else if (clr) begin
      armed    <= 1'b0;
      match_q  <= 1'b0;
      ringing  <= 1'b0;
      ring_cnt <= '0;
      snz_cnt  <= '0;
    end else if (wr) begin
      alm      <= hhmm_t'(set_val);
      armed    <= 1'b1;
      match_q  <= 1'b0;
      ringing  <= 1'b0;
      ring_cnt <= '0;
      snz_cnt  <= '0;
    end else begin
      match_q <= match;
      if (stop) begin
        ringing  <= 1'b0;
        ring_cnt <= '0;
        snz_cnt  <= '0;
      end else if (snooze && ringing) begin
        ringing  <= 1'b0;
        ring_cnt <= '0;
        snz_cnt  <= SNZ_LD;
      end else if (trig) begin
        ringing  <= 1'b1;
        ring_cnt <= RING_LD;
        snz_cnt  <= '0;
      end else if (sec_tick) begin
        if (ringing) begin
          ring_cnt <= ring_cnt - 1'b1;
          if (ring_cnt == RW'(1))
            ringing <= 1'b0;
        end
        // snooze expiry restarts a full ring period
        if (snz_cnt != '0) begin
          snz_cnt <= snz_cnt - 1'b1;
          if (snz_cnt == SW'(1)) begin
            ringing  <= 1'b1;
            ring_cnt <= RING_LD;
          end
        end
      end
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze;

  always_ff @(posedge clk) begin
    if (rst) begin
      alm      <= '0;
      armed    <= 1'b0;
      match_q  <= 1'b0;
      ringing  <= 1'b0;
      ring_cnt <= '0;
    end else if (clr) begin
      armed    <= 1'b0;
      match_q  <= 1'b0;
      ringing  <= 1'b0;
      ring_cnt <= '0;
    end else if (wr) begin
      alm      <= hhmm_t'(set_val);
      armed    <= 1'b1;
      match_q  <= 1'b0;
      ringing  <= 1'b0;
      ring_cnt <= '0;
    end else begin
      match_q <= match;
      if (stop) begin
        ringing  <= 1'b0;
        ring_cnt <= '0;
      end else if (trig) begin
        ringing  <= 1'b1;
        ring_cnt <= RING_LD;
      end else if (sec_tick && ringing) begin
        ring_cnt <= ring_cnt - 1'b1;
        if (ring_cnt == RW'(1))
          ringing <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: rtl/alarm_bank.sv
// N-channel alarm bank beside the BCD time counter.
// Optional snooze support is enabled by defining ALARM_SNOOZE_EN.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int N_ALARMS    = 4,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  localparam int CH_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sec_tick,
  input  logic [3:0]          time_h_t,
  input  logic [3:0]          time_h_o,
  input  logic [3:0]          time_m_t,
  input  logic [3:0]          time_m_o,
  input  logic [CH_W-1:0]     set_sel,
  input  logic [3:0]          set_h_t,
  input  logic [3:0]          set_h_o,
  input  logic [3:0]          set_m_t,
  input  logic [3:0]          set_m_o,
  input  logic                set_wr,
  input  logic                clr_wr,
  input  logic                stop,
  input  logic                snooze,
  output logic                ring,
  output logic [N_ALARMS-1:0] ring_vec,
  output logic [N_ALARMS-1:0] armed_vec
);

  hhmm_t now;
  hhmm_t set_val;
  logic  sel_ok;

  assign now     = '{time_h_t, time_h_o, time_m_t, time_m_o};
  assign set_val = '{set_h_t, set_h_o, set_m_t, set_m_o};
  assign sel_ok  = int'(set_sel) < N_ALARMS;
  assign ring    = |ring_vec;

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_slot
    logic hit;
    assign hit = sel_ok && (set_sel == CH_W'(i));

    alarm_slot #(
      .RING_SECS   (RING_SECS),
      .SNOOZE_SECS (SNOOZE_SECS)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .sec_tick (sec_tick),
      .now      (now),
      .set_val  (set_val),
      .wr       (set_wr & hit),
      .clr      (clr_wr & hit),
      .stop     (stop),
      .snooze   (snooze),
      .ringing  (ring_vec[i]),
      .armed    (armed_vec[i])
    );
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed scoreboard bench for alarm_bank (5 channels, 3 s ring, 2 s snooze).
module tb_alarm_bank;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0;
  logic [3:0] time_h_t = '0, time_h_o = '0;
  logic [3:0] time_m_t = '0, time_m_o = '0;
  logic [2:0] set_sel = '0;
  logic [3:0] set_h_t = '0, set_h_o = '0;
  logic [3:0] set_m_t = '0, set_m_o = '0;
  logic       set_wr = 1'b0, clr_wr = 1'b0;
  logic       stop = 1'b0, snooze = 1'b0;
  logic       ring;
  logic [N-1:0] ring_vec, armed_vec;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string        tag;
    logic [N-1:0] rv;
    logic [N-1:0] av;
  } exp_t;

  exp_t q[$];

  alarm_bank #(
    .N_ALARMS    (N),
    .RING_SECS   (3),
    .SNOOZE_SECS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sec_tick  (sec_tick),
    .time_h_t  (time_h_t),
    .time_h_o  (time_h_o),
    .time_m_t  (time_m_t),
    .time_m_o  (time_m_o),
    .set_sel   (set_sel),
    .set_h_t   (set_h_t),
    .set_h_o   (set_h_o),
    .set_m_t   (set_m_t),
    .set_m_o   (set_m_o),
    .set_wr    (set_wr),
    .clr_wr    (clr_wr),
    .stop      (stop),
    .snooze    (snooze),
    .ring      (ring),
    .ring_vec  (ring_vec),
    .armed_vec (armed_vec)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk();
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL sb_empty got 0 entries want 1");
      return;
    end
    e = q.pop_front();
    n_cmp++;
    assert (ring_vec === e.rv) else begin
      n_bad++;
      $error("FAIL %s ring_vec got %b want %b", e.tag, ring_vec, e.rv);
    end
    n_cmp++;
    assert (armed_vec === e.av) else begin
      n_bad++;
      $error("FAIL %s armed_vec got %b want %b", e.tag, armed_vec, e.av);
    end
    n_cmp++;
    assert (ring === (|e.rv)) else begin
      n_bad++;
      $error("FAIL %s ring got %b want %b", e.tag, ring, |e.rv);
    end
  endtask

  task automatic step(input string tag, input logic [N-1:0] rv,
                      input logic [N-1:0] av);
    q.push_back('{tag, rv, av});
    cyc();
    chk();
  endtask

  task automatic now_is(input logic [3:0] a, b, c, d);
    time_h_t = a; time_h_o = b; time_m_t = c; time_m_o = d;
  endtask

  task automatic alm_is(input logic [2:0] ch, input logic [3:0] a, b, c, d);
    set_sel = ch;
    set_h_t = a; set_h_o = b; set_m_t = c; set_m_o = d;
  endtask

  initial begin
    // reset
    step("rst_a", 5'b00000, 5'b00000);
    step("rst_b", 5'b00000, 5'b00000);
    rst = 1'b0;
    cyc();
    step("post_rst", 5'b00000, 5'b00000);

    // basic fire and timeout on ch1
    now_is(0, 7, 2, 9);
    alm_is(1, 0, 7, 3, 0);
    set_wr = 1'b1;
    step("set_ch1", 5'b00000, 5'b00010);
    set_wr = 1'b0;
    step("pre_match", 5'b00000, 5'b00010);
    now_is(0, 7, 3, 0);
    step("fire_ch1", 5'b00010, 5'b00010);
    sec_tick = 1'b1;
    step("tick1", 5'b00010, 5'b00010);
    step("tick2", 5'b00010, 5'b00010);
    step("tick3", 5'b00000, 5'b00010);
    sec_tick = 1'b0;
    cyc();
    step("no_refire", 5'b00000, 5'b00010);

    // stop with ch0 and ch2 ringing
    alm_is(0, 0, 8, 1, 5);
    set_wr = 1'b1;
    step("set_ch0", 5'b00000, 5'b00011);
    alm_is(2, 0, 8, 1, 5);
    step("set_ch2", 5'b00000, 5'b00111);
    set_wr = 1'b0;
    now_is(0, 8, 1, 5);
    step("fire_02", 5'b00101, 5'b00111);
    stop = 1'b1;
    step("stop", 5'b00000, 5'b00111);
    stop = 1'b0;
    cyc();
    step("stop_norefire", 5'b00000, 5'b00111);

    // set/clr collision and out-of-range select
    alm_is(3, 0, 8, 1, 5);
    set_wr = 1'b1;
    clr_wr = 1'b1;
    step("collide_ch3", 5'b00000, 5'b00111);
    clr_wr = 1'b0;
    alm_is(5, 0, 8, 1, 5);
    step("bad_sel", 5'b00000, 5'b00111);
    set_wr = 1'b0;
    step("bad_sel_idle", 5'b00000, 5'b00111);
    set_sel = 3'd2;
    clr_wr = 1'b1;
    step("clr_ch2", 5'b00000, 5'b00011);
    clr_wr = 1'b0;

    // re-arm at the current time
    now_is(1, 2, 0, 0);
    alm_is(0, 1, 2, 0, 0);
    set_wr = 1'b1;
    step("rearm_set", 5'b00000, 5'b00011);
    set_wr = 1'b0;
    step("rearm_fire", 5'b00001, 5'b00011);

`ifdef ALARM_SNOOZE_EN
    snooze = 1'b1;
    step("snooze", 5'b00000, 5'b00011);
    snooze = 1'b0;
    sec_tick = 1'b1;
    step("snz_tick1", 5'b00000, 5'b00011);
    step("snz_ring", 5'b00001, 5'b00011);
    sec_tick = 1'b0;
    snooze = 1'b1;
    step("snooze2", 5'b00000, 5'b00011);
    snooze = 1'b0;
    stop = 1'b1;
    step("snz_stop", 5'b00000, 5'b00011);
    stop = 1'b0;
`else
    snooze = 1'b1;
    step("snz_ignored", 5'b00001, 5'b00011);
    snooze = 1'b0;
    stop = 1'b1;
    step("stop_ch0", 5'b00000, 5'b00011);
    stop = 1'b0;
`endif
    sec_tick = 1'b1;
    step("quiet_t1", 5'b00000, 5'b00011);
    step("quiet_t2", 5'b00000, 5'b00011);
    sec_tick = 1'b0;
    step("quiet_end", 5'b00000, 5'b00011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
